// File: rtl/pow2_interp_pipe.sv
// frac(2^x) = 2^x - 1 by table lookup plus rounded linear interpolation; 3-cycle latency, 1 beat/cycle.
// A single advance enable stalls every stage together when the output is held; in_ready is that enable.
module pow2_interp_pipe #(
  parameter int IN_WIDTH  = 8,
  parameter int LUT_BITS  = 4,
  parameter int OUT_WIDTH = 8,
  parameter int TAG_WIDTH = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int F  = IN_WIDTH - LUT_BITS;
  localparam int FW = (F > 0) ? F : 1;
  localparam int N  = 1 << LUT_BITS;
  localparam int TW = OUT_WIDTH + 1;
  localparam int PW = TW + FW;

  localparam logic [PW-1:0] RND   = (F > 0) ? ((PW'(1) << FW) >> 1) : PW'(0);
  localparam logic [TW:0]   LIMIT = (TW + 1)'(1) << OUT_WIDTH;

  typedef logic [TW-1:0] tval_t;

  function automatic tval_t lut_entry(input int i);
    real v;
    v = (2.0 ** (real'(i) / real'(N)) - 1.0) * (2.0 ** OUT_WIDTH);
    return tval_t'($rtoi(v + 0.5));
  endfunction

  generate
    if (IN_WIDTH < LUT_BITS) begin : g_bad_width
      $error("IN_WIDTH must be >= LUT_BITS");
    end
    if (TAG_WIDTH < 1) begin : g_bad_tag
      $error("TAG_WIDTH must be >= 1");
    end
  endgenerate

  // Table has one extra entry so hi+1 is always valid; the last entry is exactly 2^OUT_WIDTH.
  tval_t lut [N+1];
  generate
    for (genvar g = 0; g <= N; g++) begin : g_lut
      localparam tval_t ENTRY = lut_entry(g);
      assign lut[g] = ENTRY;
    end
  endgenerate

  logic [LUT_BITS:0] idx;
  logic [LUT_BITS:0] idx_nxt;
  logic [FW-1:0]     lo_in;

  assign idx     = {1'b0, in_data[IN_WIDTH-1 -: LUT_BITS]};
  assign idx_nxt = idx + 1'b1;

  generate
    if (F > 0) begin : g_lo
      assign lo_in = in_data[FW-1:0];
    end else begin : g_no_lo
      assign lo_in = '0;
    end
  endgenerate

  logic adv;

  logic                 s1_vld_q, s2_vld_q, s3_vld_q;
  logic [TAG_WIDTH-1:0] s1_tag_q, s2_tag_q, s3_tag_q;
  tval_t                s1_base_q, s1_diff_q;
  logic [FW-1:0]        s1_lo_q;
  tval_t                s2_base_q, s2_term_q;
  logic [OUT_WIDTH-1:0] s3_dat_q;

  tval_t                s1_base_d, s1_diff_d;
  logic [PW-1:0]        s2_prod;
  tval_t                s2_term_d;
  logic [TW:0]          s3_sum;
  logic [OUT_WIDTH-1:0] s3_dat_d;

  assign adv      = !s3_vld_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    s1_base_d = lut[idx];
    s1_diff_d = lut[idx_nxt] - lut[idx];
    // With F = 0 the low part is constant zero, so the term collapses to zero.
    s2_prod   = PW'(s1_diff_q) * PW'(s1_lo_q) + RND;
    s2_term_d = TW'(s2_prod >> F);
    s3_sum    = {1'b0, s2_base_q} + {1'b0, s2_term_q};
    s3_dat_d  = (s3_sum >= LIMIT) ? {OUT_WIDTH{1'b1}} : s3_sum[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      s3_dat_q <= '0;
      s3_tag_q <= '0;
    end else if (adv) begin
      s1_vld_q <= in_valid;
      s2_vld_q <= s1_vld_q;
      s3_vld_q <= s2_vld_q;
      s3_dat_q <= s3_dat_d;
      s3_tag_q <= s2_tag_q;
    end
  end

  // Internal data stages carry no reset; their contents are qualified by the valid bits.
  always_ff @(posedge clock) begin
    if (adv) begin
      s1_tag_q  <= in_tag;
      s1_base_q <= s1_base_d;
      s1_diff_q <= s1_diff_d;
      s1_lo_q   <= lo_in;
      s2_tag_q  <= s1_tag_q;
      s2_base_q <= s1_base_q;
      s2_term_q <= s2_term_d;
    end
  end

  assign out_valid = s3_vld_q;
  assign out_data  = s3_dat_q;
  assign out_tag   = s3_tag_q;

endmodule

// File: tb/tb_pow2_interp_pipe.sv
// Randomized and directed bench for pow2_interp_pipe against a real-valued reference model.
module tb_pow2_interp_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [3:0] in_tag, out_tag;

  logic       s_in_valid, s_in_ready, s_out_valid, s_in_tag, s_out_tag;
  logic [7:0] s_in_data;
  logic [3:0] s_out_data;

  logic       z_in_valid, z_in_ready, z_out_valid, z_in_tag, z_out_tag;
  logic [3:0] z_in_data;
  logic [7:0] z_out_data;

  logic one = 1'b1;

  pow2_interp_pipe #(.IN_WIDTH(8), .LUT_BITS(4), .OUT_WIDTH(8), .TAG_WIDTH(4)) u_dut (
    .clock(clk), .reset(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  pow2_interp_pipe #(.IN_WIDTH(8), .LUT_BITS(2), .OUT_WIDTH(4), .TAG_WIDTH(1)) u_sat (
    .clock(clk), .reset(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_tag(s_in_tag),
    .out_valid(s_out_valid), .out_ready(one), .out_data(s_out_data), .out_tag(s_out_tag)
  );

  pow2_interp_pipe #(.IN_WIDTH(4), .LUT_BITS(4), .OUT_WIDTH(8), .TAG_WIDTH(1)) u_f0 (
    .clock(clk), .reset(rst),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data), .in_tag(z_in_tag),
    .out_valid(z_out_valid), .out_ready(one), .out_data(z_out_data), .out_tag(z_out_tag)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int tbl(input int i, input int lb, input int ow);
    real v;
    v = (2.0 ** (real'(i) / (2.0 ** lb)) - 1.0) * (2.0 ** ow);
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic int model(input int x, input int iw, input int lb, input int ow);
    int f, hi, lo, t0, t1, y;
    f  = iw - lb;
    hi = x >> f;
    lo = x - (hi << f);
    t0 = tbl(hi, lb, ow);
    t1 = tbl(hi + 1, lb, ow);
    y  = t0 + $rtoi($floor(real'(t1 - t0) * real'(lo) / (2.0 ** f) + 0.5));
    return (y >= (1 << ow)) ? (1 << ow) - 1 : y;
  endfunction

  // Scoreboard: expected results in acceptance order, flushed by reset.
  int q_dat[$];
  int q_tag[$];

  always @(negedge clk) begin
    if (rst) begin
      q_dat.delete();
      q_tag.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q_dat.size() == 0) check("spurious_out", int'(out_valid), 0);
        else begin
          check("sb_dat", int'(out_data), q_dat.pop_front());
          check("sb_tag", int'(out_tag), q_tag.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q_dat.push_back(model(int'(in_data), 8, 4, 8));
        q_tag.push_back(int'(in_tag));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && q_dat.size() != 0; c++) cyc();
    check("drain_empty", q_dat.size(), 0);
  endtask

  logic [7:0] dir_in  [4] = '{8'h00, 8'h30, 8'h18, 8'hFF};
  int         dir_exp [4] = '{0, 36, 17, 255};

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_in_tag = 1'b0;
    z_in_valid = 1'b0; z_in_data = '0; z_in_tag = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_tag", int'(out_tag), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // Directed beats with exact latency.
    cyc();
    in_valid = 1'b1; in_data = dir_in[0]; in_tag = 4'd1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k < 4) begin
        in_data = dir_in[k];
        in_tag  = 4'(k + 1);
      end else in_valid = 1'b0;
      @(negedge clk);
      if (k < 3) check("dir_latency_idle", int'(out_valid), 0);
      else begin
        check("dir_vld", int'(out_valid), 1);
        check("dir_dat", int'(out_data), dir_exp[k-3]);
        check("dir_tag", int'(out_tag), k - 2);
      end
    end
    drain();

    // Exhaustive sweep with random tags.
    for (int v = 0; v < 256; v++) begin
      in_valid = 1'b1; in_data = 8'(v); in_tag = 4'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    drain();

    // Stall for 5 cycles as the first result appears.
    in_valid = 1'b1;
    for (int c = 0; c < 20 && !out_valid; c++) begin
      in_data = 8'($urandom); in_tag = 4'($urandom);
      cyc();
    end
    check("stall_first_result", int'(out_valid), 1);
    out_ready = 1'b0;
    #1;
    check("stall_in_ready_drop", int'(in_ready), 0);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("stall_vld", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_fill", q_dat.size(), 3);
      check("stall_dat", int'(out_data), q_dat.size() > 0 ? q_dat[0] : -1);
      check("stall_tag", int'(out_tag), q_tag.size() > 0 ? q_tag[0] : -1);
      cyc();
      in_data = 8'($urandom); in_tag = 4'($urandom);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = 8'($urandom); in_tag = 4'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    drain();

    // Random valid/ready traffic.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_tag    = 4'($urandom);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Reset with three beats in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = 8'($urandom); in_tag = 4'($urandom);
      cyc();
    end
    check("flush_pre_vld", int'(out_valid), 1);
    rst = 1'b1; in_valid = 1'b0;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("flush_vld", int'(out_valid), 0);
    check("flush_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    repeat (10) cyc();
    in_valid = 1'b1; in_data = 8'hA0; in_tag = 4'd5;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      if (k < 3) check("post_rst_idle", int'(out_valid), 0);
      else begin
        check("post_rst_vld", int'(out_valid), 1);
        check("post_rst_dat", int'(out_data), 139);
        check("post_rst_tag", int'(out_tag), 5);
      end
    end
    drain();

    // Saturation build and F = 0 build.
    cyc();
    s_in_valid = 1'b1; s_in_data = 8'hFF; s_in_tag = 1'b1;
    z_in_valid = 1'b1; z_in_data = 4'h3;  z_in_tag = 1'b1;
    cyc();
    s_in_valid = 1'b0;
    z_in_data = 4'hC; z_in_tag = 1'b0;
    cyc();
    z_in_valid = 1'b0;
    @(negedge clk);
    check("f0_idle", int'(z_out_valid), 0);
    check("sat_idle", int'(s_out_valid), 0);
    cyc();
    @(negedge clk);
    check("sat_vld", int'(s_out_valid), 1);
    check("sat_dat", int'(s_out_data), 15);
    check("sat_tag", int'(s_out_tag), 1);
    check("f0_vld0", int'(z_out_valid), 1);
    check("f0_dat0", int'(z_out_data), 36);
    check("f0_tag0", int'(z_out_tag), 1);
    cyc();
    @(negedge clk);
    check("f0_vld1", int'(z_out_valid), 1);
    check("f0_dat1", int'(z_out_data), 175);
    check("f0_tag1", int'(z_out_tag), 0);
    check("sat_done", int'(s_out_valid), 0);
    check("f0_in_ready", int'(z_in_ready), 1);
    check("sat_in_ready", int'(s_in_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
